// File: rtl/tc_systolic_seq_ctrl.sv
// rtl/tc_systolic_seq_ctrl.sv - tensor-core systolic job sequencer
// Walks A/B tile pairs, drives buffer loads, systolic/accumulate phases and writeback.
module tc_systolic_seq_ctrl #(
   parameter int SYS_CYCLES = 32,
   parameter int ACC_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] full_type,
   output logic       ld_req,
   output logic [1:0] ld_sel,
   output logic       ld_buf,
   input  logic       ld_done,
   output logic       sys_en,
   output logic       rd_buf,
   output logic       acc_en,
   output logic [2:0] pattern,
   output logic       wb_req,
   input  logic       wb_done,
   output logic [1:0] a_idx,
   output logic [1:0] b_idx,
   output logic [3:0] state,
   output logic       busy,
   output logic       done,
   output logic       cfg_err
);

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      READ_C      = 4'd1,
      INIT_WAIT_C = 4'd2,
      INIT_WAIT_A = 4'd3,
      INIT_WAIT_B = 4'd4,
      SYSTOLIC    = 4'd5,
      ACCUMULATE  = 4'd6,
      WRITE_BACK  = 4'd7,
      RESET_B     = 4'd8,
      RESET_A     = 4'd9,
      FINISH      = 4'd10
   } state_t;

   typedef enum logic [1:0] {MAT_A = 2'd0, MAT_B = 2'd1, MAT_C = 2'd2} mat_t;
   typedef enum logic [2:0] {NOMAL = 3'd0, BROADCAST = 3'd1} pattern_t;

   localparam logic [5:0] SYS_LAST = 6'(SYS_CYCLES - 1);
   localparam logic [5:0] ACC_LAST = 6'(ACC_CYCLES - 1);

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic [2:0] na_q, na_d, nb_q, nb_d;
   logic       acc_q, acc_d;
   logic [1:0] a_idx_q, a_idx_d, b_idx_q, b_idx_d;
   logic       rd_buf_q, rd_buf_d;
   logic       ld_req_q, ld_req_d;
   mat_t       ld_sel_q, ld_sel_d;
   logic       ld_buf_q, ld_buf_d;
   logic       pf_done_q, pf_done_d;
   logic       cfg_err_q, cfg_err_d;
   logic       ld_fire, more_a, more_b;
   logic [1:0] shape;

   assign ld_fire = ld_req_q & ld_done;
   assign more_a  = ({1'b0, a_idx_q} + 3'd1) < na_q;
   assign more_b  = ({1'b0, b_idx_q} + 3'd1) < nb_q;
   assign shape   = 2'(full_type % 4'd3);

   always_comb begin
      state_d   = state_q;
      na_d      = na_q;
      nb_d      = nb_q;
      acc_d     = acc_q;
      a_idx_d   = a_idx_q;
      b_idx_d   = b_idx_q;
      rd_buf_d  = rd_buf_q;
      ld_req_d  = ld_req_q;
      ld_sel_d  = ld_sel_q;
      ld_buf_d  = ld_buf_q;
      pf_done_d = pf_done_q;
      cfg_err_d = 1'b0;

      // Only a prefetch can be outstanding while the array is working on a tile pair.
      if (ld_fire && (state_q == SYSTOLIC || state_q == ACCUMULATE || state_q == WRITE_BACK)) begin
         ld_req_d  = 1'b0;
         pf_done_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (full_type > 4'd11) begin
                  cfg_err_d = 1'b1;
               end else begin
                  state_d = READ_C;
                  case (shape)
                     2'd1:    begin na_d = 3'd1; nb_d = 3'd4; end
                     2'd2:    begin na_d = 3'd4; nb_d = 3'd1; end
                     default: begin na_d = 3'd2; nb_d = 3'd2; end
                  endcase
                  acc_d     = (full_type >= 4'd6);
                  a_idx_d   = 2'd0;
                  b_idx_d   = 2'd0;
                  rd_buf_d  = 1'b0;
                  pf_done_d = 1'b0;
                  ld_req_d  = 1'b1;
                  ld_sel_d  = MAT_C;
                  ld_buf_d  = 1'b0;
               end
            end
         end
         READ_C, INIT_WAIT_C: begin
            state_d = INIT_WAIT_C;
            if (ld_fire) begin
               state_d  = INIT_WAIT_A;
               ld_sel_d = MAT_A;
            end
         end
         INIT_WAIT_A: begin
            if (ld_fire) begin
               state_d  = INIT_WAIT_B;
               ld_sel_d = MAT_B;
               ld_buf_d = rd_buf_q;
            end
         end
         INIT_WAIT_B: begin
            if (ld_fire) begin
               state_d   = SYSTOLIC;
               ld_req_d  = 1'b0;
               pf_done_d = 1'b0;
            end
         end
         SYSTOLIC: begin
            if (cnt_q == SYS_LAST) state_d = acc_q ? ACCUMULATE : WRITE_BACK;
         end
         ACCUMULATE: begin
            if (cnt_q == ACC_LAST) state_d = WRITE_BACK;
         end
         WRITE_BACK: begin
            if (wb_done) begin
               if (more_b)      state_d = RESET_B;
               else if (more_a) state_d = RESET_A;
               else             state_d = FINISH;
            end
         end
         RESET_B: begin
            b_idx_d  = b_idx_q + 2'd1;
            rd_buf_d = ~rd_buf_q;
            if (pf_done_q || ld_fire) begin
               state_d   = SYSTOLIC;
               pf_done_d = 1'b0;
               ld_req_d  = 1'b0;
            end else begin
               state_d = INIT_WAIT_B;
            end
         end
         RESET_A: begin
            state_d   = READ_C;
            a_idx_d   = a_idx_q + 2'd1;
            b_idx_d   = 2'd0;
            rd_buf_d  = 1'b0;
            pf_done_d = 1'b0;
            ld_req_d  = 1'b1;
            ld_sel_d  = MAT_C;
            ld_buf_d  = 1'b0;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Prefetch the next B tile into the idle buffer half as the array starts streaming.
      if (state_d == SYSTOLIC && state_q != SYSTOLIC && (({1'b0, b_idx_d} + 3'd1) < nb_q)) begin
         ld_req_d  = 1'b1;
         ld_sel_d  = MAT_B;
         ld_buf_d  = ~rd_buf_d;
         pf_done_d = 1'b0;
      end

      cnt_d = (state_d == state_q) ? cnt_q + 6'd1 : 6'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 6'd0;
         na_q      <= 3'd0;
         nb_q      <= 3'd0;
         acc_q     <= 1'b0;
         a_idx_q   <= 2'd0;
         b_idx_q   <= 2'd0;
         rd_buf_q  <= 1'b0;
         ld_req_q  <= 1'b0;
         ld_sel_q  <= MAT_A;
         ld_buf_q  <= 1'b0;
         pf_done_q <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         na_q      <= na_d;
         nb_q      <= nb_d;
         acc_q     <= acc_d;
         a_idx_q   <= a_idx_d;
         b_idx_q   <= b_idx_d;
         rd_buf_q  <= rd_buf_d;
         ld_req_q  <= ld_req_d;
         ld_sel_q  <= ld_sel_d;
         ld_buf_q  <= ld_buf_d;
         pf_done_q <= pf_done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign ld_req  = ld_req_q;
   assign ld_sel  = ld_sel_q;
   assign ld_buf  = ld_buf_q;
   assign sys_en  = (state_q == SYSTOLIC);
   assign acc_en  = (state_q == ACCUMULATE);
   assign wb_req  = (state_q == WRITE_BACK);
   assign rd_buf  = rd_buf_q;
   assign a_idx   = a_idx_q;
   assign b_idx   = b_idx_q;
   assign state   = state_q;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == FINISH);
   assign cfg_err = cfg_err_q;
   assign pattern = (busy && acc_q) ? BROADCAST : NOMAL;

endmodule

// File: tb/tb_tc_systolic_seq_ctrl.sv
// tb/tb_tc_systolic_seq_ctrl.sv - bench for tc_systolic_seq_ctrl
// Table of job types with hand-computed totals, plus prefetch-stall, cfg_err and reset sequences.
module tb_tc_systolic_seq_ctrl;

   logic       clk, rst, start, ld_done, wb_done;
   logic [3:0] full_type;
   logic       ld_req, ld_buf, sys_en, rd_buf, acc_en, wb_req, busy, done, cfg_err;
   logic [1:0] ld_sel, a_idx, b_idx;
   logic [2:0] pattern;
   logic [3:0] state;

   tc_systolic_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .full_type(full_type),
      .ld_req(ld_req), .ld_sel(ld_sel), .ld_buf(ld_buf), .ld_done(ld_done),
      .sys_en(sys_en), .rd_buf(rd_buf), .acc_en(acc_en), .pattern(pattern),
      .wb_req(wb_req), .wb_done(wb_done), .a_idx(a_idx), .b_idx(b_idx),
      .state(state), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   typedef struct {
      logic [3:0] ft;
      int ld; int pf; int sys; int acc; int wb; int max_a; int max_b; int pat;
   } vec_t;

   vec_t vecs[6];
   int   exp_order[8];
   int   n_vec = 0, n_err = 0;

   int ld_lat, pf_lat, wb_lat;
   int ld_age, wb_age;
   bit ld_pend, ld_is_pf;
   int ld_cnt, pf_cnt, tog_cnt, sys_cyc, acc_cyc, wb_cnt, done_cnt, max_a, max_b, pat_bad, cur_pat;
   int sel_log[16];
   logic [3:0] prev_state;
   logic       prev_rd;
   wire [21:0] out_bits = {ld_req, ld_sel, ld_buf, sys_en, rd_buf, acc_en, pattern, wb_req,
                           a_idx, b_idx, state, busy, done, cfg_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Loader/writeback responder and statistics monitor.
   initial begin
      ld_done = 1'b0; wb_done = 1'b0;
      ld_pend = 1'b0; ld_is_pf = 1'b0; ld_age = 0; wb_age = 0;
      prev_state = 4'd0; prev_rd = 1'b0;
      forever begin
         @(negedge clk);
         ld_done = 1'b0;
         wb_done = 1'b0;
         if (rst) begin
            ld_pend = 1'b0; ld_age = 0; wb_age = 0;
         end else begin
            if (ld_req) begin
               if (!ld_pend) begin
                  ld_pend  = 1'b1;
                  ld_age   = 0;
                  ld_is_pf = (state == 4'd5);
                  if (ld_cnt < 16) sel_log[ld_cnt] = int'(ld_sel);
                  ld_cnt++;
                  if (ld_is_pf) pf_cnt++;
               end
               ld_age++;
               if (ld_age >= (ld_is_pf ? pf_lat : ld_lat)) begin
                  ld_done = 1'b1;
                  ld_pend = 1'b0;
               end
            end
            if (wb_req) begin
               wb_age++;
               if (wb_age >= wb_lat) begin
                  wb_done = 1'b1;
                  wb_age  = 0;
                  wb_cnt++;
               end
            end
         end
         if (sys_en) sys_cyc++;
         if (acc_en) acc_cyc++;
         if (done) done_cnt++;
         if (prev_state == 4'd8 && rd_buf != prev_rd) tog_cnt++;
         if (busy && int'(a_idx) > max_a) max_a = int'(a_idx);
         if (busy && int'(b_idx) > max_b) max_b = int'(b_idx);
         if (busy && int'(pattern) != cur_pat) pat_bad++;
         prev_state = state;
         prev_rd    = rd_buf;
      end
   end

   task automatic clear_stats(input int pat);
      ld_cnt = 0; pf_cnt = 0; tog_cnt = 0; sys_cyc = 0; acc_cyc = 0; wb_cnt = 0;
      done_cnt = 0; max_a = 0; max_b = 0; pat_bad = 0; cur_pat = pat;
      for (int i = 0; i < 16; i++) sel_log[i] = -1;
   endtask

   task automatic start_job(input logic [3:0] ft);
      @(negedge clk); #1;
      start = 1'b1; full_type = ft;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_job(input string name);
      bit ended = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         if (done_cnt > 0 && !busy) begin
            ended = 1'b1;
            break;
         end
      end
      check({name, "_job_end"}, int'(ended), 1);
   endtask

   task automatic check_vec(input string name, input vec_t v);
      check({name, "_loads"},     ld_cnt,       v.ld);
      check({name, "_prefetch"},  pf_cnt,       v.pf);
      check({name, "_rdbuf_tog"}, tog_cnt,      v.pf);
      check({name, "_sys_cyc"},   sys_cyc,      v.sys);
      check({name, "_acc_cyc"},   acc_cyc,      v.acc);
      check({name, "_wb"},        wb_cnt,       v.wb);
      check({name, "_done"},      done_cnt,     1);
      check({name, "_max_a"},     max_a,        v.max_a);
      check({name, "_max_b"},     max_b,        v.max_b);
      check({name, "_pattern"},   pat_bad,      0);
      check({name, "_busy_end"},  int'(busy),   0);
   endtask

   task automatic check_order(input string name);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_order_%0d", name, i), sel_log[i], exp_order[i]);
   endtask

   task automatic wait_state(input string name, input logic [3:0] s);
      bit hit = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (state == s) begin
            hit = 1'b1;
            break;
         end
      end
      check({name, "_reach"}, int'(hit), 1);
   endtask

   initial begin
      bit d;
      int wait_cyc, bad;

      //            ft     ld  pf  sys  acc wb maxa maxb pat
      vecs[0] = '{4'd0,   8,  2, 128,  0, 4, 1, 1, 0};
      vecs[1] = '{4'd7,   6,  3, 128, 16, 4, 0, 3, 1};
      vecs[2] = '{4'd5,  12,  0, 128,  0, 4, 3, 0, 0};
      vecs[3] = '{4'd9,   8,  2, 128, 16, 4, 1, 1, 1};
      vecs[4] = '{4'd4,   6,  3, 128,  0, 4, 0, 3, 0};
      vecs[5] = '{4'd11, 12,  0, 128, 16, 4, 3, 0, 1};
      exp_order = '{2, 0, 1, 1, 2, 0, 1, 1};

      ld_lat = 3; pf_lat = 3; wb_lat = 2;
      rst = 1'b1; start = 1'b0; full_type = 4'd0;
      clear_stats(0);
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", int'(out_bits), 0);
      @(negedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      check("idle_outputs", int'(out_bits), 0);

      for (int k = 0; k < 6; k++) begin
         clear_stats(vecs[k].pat);
         start_job(vecs[k].ft);
         wait_job($sformatf("vec%0d", k));
         check_vec($sformatf("vec%0d", k), vecs[k]);
         if (k == 0) check_order("vec0");
      end

      // Late prefetch: B tile arrives well after SYSTOLIC has finished.
      pf_lat = 72;
      clear_stats(0);
      start_job(4'd0);
      wait_state("pf_late_resetb", 4'd8);
      @(posedge clk); #1;
      check("pf_late_state", int'(state), 4);
      check("pf_late_ld_req", int'(ld_req), 1);
      check("pf_late_ld_sel", int'(ld_sel), 1);
      check("pf_late_ld_buf", int'(ld_buf), 1);
      d = 1'b0; wait_cyc = 0; bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         d = ld_done;
         @(posedge clk); #1;
         if (d) break;
         wait_cyc++;
         if (state != 4'd4 || !ld_req) bad++;
      end
      check("pf_late_done_seen", int'(d), 1);
      check("pf_late_held", bad, 0);
      check("pf_late_waited", int'(wait_cyc > 20), 1);
      check("pf_late_sys_next", int'(state), 5);
      wait_job("pf_late");
      check_vec("pf_late", vecs[0]);
      pf_lat = 3;

      // Invalid type, then a start while busy.
      @(negedge clk); #1;
      start = 1'b1; full_type = 4'd13;
      @(posedge clk); #1;
      check("cfg_err_pulse", int'(cfg_err), 1);
      check("cfg_err_busy", int'(busy), 0);
      @(negedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("cfg_err_clear", int'(cfg_err), 0);
      check("cfg_err_idle", int'(state), 0);
      clear_stats(0);
      start_job(4'd0);
      repeat (5) @(negedge clk);
      #1;
      start = 1'b1; full_type = 4'd7;
      @(negedge clk); #1;
      start = 1'b0;
      wait_job("busy_start");
      check_vec("busy_start", vecs[0]);

      // Reset in the middle of SYSTOLIC, then a clean rerun.
      clear_stats(0);
      start_job(4'd0);
      wait_state("mid_rst", 4'd5);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_outputs", int'(out_bits), 0);
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      clear_stats(0);
      start_job(4'd0);
      wait_job("rerun");
      check_vec("rerun", vecs[0]);
      check_order("rerun");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
